smaesh_reseed_scheduler: RTL and testbench
==========================================

Name: smaesh_reseed_scheduler

Overview:
- Enforces the randomness-refresh policy for the masked AES core.
- Counts data blocks accepted since the last PRNG reseed, and gates the data stream once a programmable limit is reached.
- Holds the data stream closed until in-flight blocks drain and a fresh seed has been absorbed.
- Sits between the top-level data handshake and the stream arbiter. Its data_enable output is ANDed into in_data_valid before the arbiter sees it.

Parameters:
CNT_W, 32, width of block counter and limit register
DEFAULT_LIMIT, 0, limit value loaded at reset (0 = unlimited)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cfg_limit_valid  input  1  new limit offered
cfg_limit_ready  output  1  limit accepted this cycle when valid&ready
cfg_limit_data  input  CNT_W  limit value (0 = unlimited)
seed_accept  input  1  pulse: seed handshake completed (in_seed_valid & in_seed_ready)
data_accept  input  1  pulse: data handshake completed (in_data_valid & in_data_ready)
prng_busy  input  1  PRNG reseed in progress
prng_seeded  input  1  PRNG holds a valid seed
aes_busy  input  1  AES core processing a block
data_enable  output  1  data stream permitted
reseed_required  output  1  limit exhausted, core idle, seed needed
blocks_since_seed  output  CNT_W  blocks accepted since last seed_accept
state_o  output  3  FSM state encoding (for status register)

Behaviour:
- States and encodings: UNSEEDED=0, RESEED=1, RUN=2, DRAIN=3, EXHAUSTED=4.
- Reset values:
  - state UNSEEDED; counter 0; limit DEFAULT_LIMIT.
  - data_enable=0, reseed_required=0, cfg_limit_ready=1.
- seed_accept has priority in every state:
  - next state is RESEED and counter clears to 0.
  - This applies even if data_accept is high the same cycle; that block is not counted.
- UNSEEDED:
  - data_enable=0.
  - If prng_seeded=1 and no seed_accept, go to RUN. This covers a seed already present after a warm reset.
- RESEED:
  - data_enable=0.
  - Go to RUN on the first cycle where prng_busy=0 and prng_seeded=1.
- RUN:
  - data_enable=1.
  - On data_accept, counter increments, saturating at 2^CNT_W-1.
  - If limit!=0 and counter+1 >= limit on a data_accept, go to DRAIN next cycle. The block reaching the limit is accepted; no further block can be accepted.
  - If prng_seeded drops to 0, go to UNSEEDED.
- DRAIN:
  - data_enable=0.
  - Go to EXHAUSTED on the first cycle with aes_busy=0; this may be the cycle after entry.
- EXHAUSTED:
  - data_enable=0, reseed_required=1.
  - Leave only via seed_accept.
- data_enable and reseed_required are pure decodes of the state register (registered, no input-to-output path).
- Counter and outputs:
  - blocks_since_seed is the counter register.
  - The counter holds its value in DRAIN and EXHAUSTED.
- Limit register and config handshake:
  - cfg_limit_ready=1 in every state except RUN and DRAIN.
  - On valid&ready, the limit updates next cycle; the counter is not altered.
  - A new limit takes effect on the next RUN entry.
- Limit 0 means the counter still counts and saturates, but DRAIN is never entered.
- Limit 1 means exactly one block per seed.
- Reset mid-operation (any state) returns to the reset values within one cycle; the limit reverts to DEFAULT_LIMIT.

Test Plan:
1. Reset with prng_seeded=0 → state_o=0, data_enable=0. Raise prng_seeded=1 → next cycle state_o=2, data_enable=1, blocks_since_seed=0.
2. Limit=3 programmed in UNSEEDED, then seed. Issue 3 data_accept pulses with aes_busy high through the cycle after the 3rd pulse:
   - data_enable drops the cycle after the 3rd pulse; state_o=3.
   - With aes_busy low, state_o=4 and reseed_required=1; blocks_since_seed=3.
   - seed_accept → state_o=1 and counter=0. With prng_busy=1 for 5 cycles then 0, state_o=2 on the first cycle prng_busy=0.
3. cfg_limit_valid in RUN → cfg_limit_ready=0, limit unchanged. Same request in EXHAUSTED → accepted, limit reads new value next cycle, counter unchanged.
4. seed_accept and data_accept in the same cycle with counter=2 → next cycle counter=0, state_o=1.
5. Limit=0, CNT_W=4 build: 20 data_accepts → counter saturates at 15, state stays 2, data_enable stays 1.
6. rst asserted in DRAIN with counter=7 → next cycle state_o=0, counter=0, limit=DEFAULT_LIMIT, data_enable=0.

Source files
------------

// File: rtl/smaesh_reseed_scheduler.sv
// Randomness-refresh policy for the masked AES core: counts blocks per seed and
// closes the data stream once the programmed limit is reached until a new seed lands.
module smaesh_reseed_scheduler #(
    parameter int unsigned      CNT_W         = 32,
    parameter logic [CNT_W-1:0] DEFAULT_LIMIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_limit_valid,
    output logic             cfg_limit_ready,
    input  logic [CNT_W-1:0] cfg_limit_data,
    input  logic             seed_accept,
    input  logic             data_accept,
    input  logic             prng_busy,
    input  logic             prng_seeded,
    input  logic             aes_busy,
    output logic             data_enable,
    output logic             reseed_required,
    output logic [CNT_W-1:0] blocks_since_seed,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        StUnseeded  = 3'd0,
        StReseed    = 3'd1,
        StRun       = 3'd2,
        StDrain     = 3'd3,
        StExhausted = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic [CNT_W:0]   cnt_inc;
    logic             cnt_max;
    logic             limit_hit;

    // One extra bit so the limit compare stays correct when the counter is saturated.
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign cnt_max   = &cnt_q;
    assign limit_hit = (limit_q != '0) && (cnt_inc >= {1'b0, limit_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;

        if (cfg_limit_valid && cfg_limit_ready) begin
            limit_d = cfg_limit_data;
        end

        if (seed_accept) begin
            state_d = StReseed;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StUnseeded: begin
                    if (prng_seeded) state_d = StRun;
                end
                StReseed: begin
                    if (!prng_busy && prng_seeded) state_d = StRun;
                end
                StRun: begin
                    if (data_accept) begin
                        if (!cnt_max) cnt_d = cnt_inc[CNT_W-1:0];
                        if (limit_hit) state_d = StDrain;
                    end
                    if (!prng_seeded) state_d = StUnseeded;
                end
                StDrain: begin
                    if (!aes_busy) state_d = StExhausted;
                end
                StExhausted: begin
                    state_d = StExhausted;
                end
                default: state_d = StUnseeded;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StUnseeded;
            cnt_q   <= '0;
            limit_q <= DEFAULT_LIMIT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

    // Outputs decode the state register only; no combinational path from inputs.
    assign data_enable       = (state_q == StRun);
    assign reseed_required   = (state_q == StExhausted);
    assign cfg_limit_ready   = (state_q != StRun) && (state_q != StDrain);
    assign blocks_since_seed = cnt_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_smaesh_reseed_scheduler.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs into a queue,
// and an independent monitor compares them against the DUT after every clock edge.
module tb_smaesh_reseed_scheduler;

    localparam int CNT_W = 4;
    localparam int DEF   = 3;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, cfg_limit_valid, cfg_limit_ready, seed_accept, data_accept;
    logic             prng_busy, prng_seeded, aes_busy, data_enable, reseed_required;
    logic [CNT_W-1:0] cfg_limit_data, blocks_since_seed;
    logic [2:0]       state_o;

    smaesh_reseed_scheduler #(
        .CNT_W        (CNT_W),
        .DEFAULT_LIMIT(4'(DEF))
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_limit_valid  (cfg_limit_valid),
        .cfg_limit_ready  (cfg_limit_ready),
        .cfg_limit_data   (cfg_limit_data),
        .seed_accept      (seed_accept),
        .data_accept      (data_accept),
        .prng_busy        (prng_busy),
        .prng_seeded      (prng_seeded),
        .aes_busy         (aes_busy),
        .data_enable      (data_enable),
        .reseed_required  (reseed_required),
        .blocks_since_seed(blocks_since_seed),
        .state_o          (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        bit de;
        bit rr;
        bit rdy;
    } exp_t;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Staged stimulus; pulses are cleared after each cycle.
    bit s_rst = 1'b0, s_cv = 1'b0, s_sa = 1'b0, s_da = 1'b0;
    bit s_pb = 1'b0, s_ps = 1'b0, s_ab = 1'b0;
    int s_cd = 0;

    // Reference model: states by name, counter and limit as plain integers.
    int m_st = 0, m_cnt = 0, m_lim = DEF;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    task automatic cyc();
        bit   rdy;
        exp_t e;
        @(negedge clk);
        rst = s_rst; cfg_limit_valid = s_cv; cfg_limit_data = 4'(s_cd);
        seed_accept = s_sa; data_accept = s_da;
        prng_busy = s_pb; prng_seeded = s_ps; aes_busy = s_ab;

        rdy = !(m_st == 2 || m_st == 3);
        if (s_rst) begin
            m_st = 0; m_cnt = 0; m_lim = DEF;
        end else begin
            if (s_cv && rdy) m_lim = s_cd;
            if (s_sa) begin
                m_st = 1; m_cnt = 0;
            end else if (m_st == 0) begin
                if (s_ps) m_st = 2;
            end else if (m_st == 1) begin
                if (!s_pb && s_ps) m_st = 2;
            end else if (m_st == 2) begin
                if (s_da) begin
                    if (m_lim != 0 && m_cnt + 1 >= m_lim) m_st = 3;
                    m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
                end
                if (!s_ps) m_st = 0;
            end else if (m_st == 3) begin
                if (!s_ab) m_st = 4;
            end
        end
        e.st = m_st; e.cnt = m_cnt;
        e.de = (m_st == 2); e.rr = (m_st == 4); e.rdy = !(m_st == 2 || m_st == 3);
        q.push_back(e);
        s_rst = 1'b0; s_cv = 1'b0; s_sa = 1'b0; s_da = 1'b0;
    endtask

    // Monitor: outputs are registered, so every cycle presents a result to compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("state", int'(state_o), e.st);
                check("blocks_since_seed", int'(blocks_since_seed), e.cnt);
                check("data_enable", int'(data_enable), int'(e.de));
                check("reseed_required", int'(reseed_required), int'(e.rr));
                check("cfg_limit_ready", int'(cfg_limit_ready), int'(e.rdy));
            end
        end
    end

    initial begin
        rst = 1'b1; cfg_limit_valid = 1'b0; cfg_limit_data = '0; seed_accept = 1'b0;
        data_accept = 1'b0; prng_busy = 1'b0; prng_seeded = 1'b0; aes_busy = 1'b0;

        // Reset unseeded, then seed appears.
        s_rst = 1'b1; cyc();
        cyc(); cyc();
        s_ps = 1'b1; cyc(); cyc();

        // Limit 3 programmed while unseeded, then a full reseed cycle.
        s_rst = 1'b1; s_ps = 1'b0; cyc();
        s_cv = 1'b1; s_cd = 3; cyc();
        s_sa = 1'b1; s_pb = 1'b1; cyc();
        s_pb = 1'b0; s_ps = 1'b1; cyc();
        s_ab = 1'b1;
        repeat (3) begin s_da = 1'b1; cyc(); end
        cyc();
        s_ab = 1'b0; cyc(); cyc();
        s_sa = 1'b1; s_pb = 1'b1; cyc();
        repeat (4) cyc();
        s_pb = 1'b0; cyc(); cyc();

        // Limit request in RUN is refused; the old limit of 3 still applies.
        s_cv = 1'b1; s_cd = 9; cyc();
        s_ab = 1'b1;
        repeat (3) begin s_da = 1'b1; cyc(); end
        s_ab = 1'b0; cyc(); cyc();
        // Accepted in EXHAUSTED; counter untouched.
        s_cv = 1'b1; s_cd = 1; cyc(); cyc();
        // Limit 1: exactly one block per seed.
        s_sa = 1'b1; cyc(); cyc();
        s_da = 1'b1; cyc(); cyc(); cyc();

        // Seed and data on the same cycle with counter 2.
        s_cv = 1'b1; s_cd = 0; cyc();
        s_sa = 1'b1; cyc(); cyc();
        s_da = 1'b1; cyc(); s_da = 1'b1; cyc();
        s_sa = 1'b1; s_da = 1'b1; cyc(); cyc();

        // Unlimited: counter saturates at 15, stays in RUN.
        repeat (20) begin s_da = 1'b1; cyc(); end
        cyc();

        // Reset while draining with counter 7.
        s_sa = 1'b1; cyc(); cyc(); cyc();
        s_sa = 1'b1; cyc();
        s_cv = 1'b1; s_cd = 7; cyc();
        s_sa = 1'b1; cyc(); cyc();
        s_ab = 1'b1;
        repeat (7) begin s_da = 1'b1; cyc(); end
        cyc();
        s_rst = 1'b1; cyc();
        s_ab = 1'b0; cyc();
        // Default limit 3 restored.
        repeat (3) begin s_da = 1'b1; cyc(); end
        cyc(); cyc();

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            s_rst = ($urandom_range(0, 99) < 1);
            s_sa  = ($urandom_range(0, 99) < 6);
            s_cv  = ($urandom_range(0, 99) < 10);
            s_cd  = int'($urandom_range(0, 5));
            s_pb  = ($urandom_range(0, 99) < 40);
            s_ps  = ($urandom_range(0, 99) < 95);
            s_ab  = ($urandom_range(0, 99) < 50);
            s_da  = (m_st == 2) && ($urandom_range(0, 99) < 60);
            cyc();
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
